// File: rtl/bytebasher_pkg.sv
// Shared definitions for the ByteBasher hit-detection path: FSM state
// encoding, the idle sensor code and the default debounce length.
package bytebasher_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [2:0]  NO_HIT           = 3'b000;
  localparam int unsigned DEFAULT_DEBOUNCE = 500000;

endpackage

// File: rtl/sensor_sync.sv
// Two-stage synchronizer bringing the raw sensor code into the clk domain.
module sensor_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hit_detector.sv
// Debounces the sensor box code, reports one hit per press and keeps
// saturating score / miss counters against the lit target box.
module hit_detector
  import bytebasher_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned SCORE_WIDTH     = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [2:0]             box_address,
  input  logic [2:0]             target_box,
  input  logic                   target_valid,
  input  logic                   score_clr,
  output logic                   hit_valid,
  output logic [2:0]             hit_box,
  output logic                   hit_correct,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] miss_count
);

  localparam int unsigned      CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [2:0]       sync_code;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;

  sensor_sync #(.WIDTH(3)) u_sync (
    .clk (CLOCK_50),
    .rst (reset),
    .d   (box_address),
    .q   (sync_code)
  );

  // Target is judged only while REPORT is active, so it is combinational.
  always_comb begin
    hit_correct = 1'b0;
    if (state == REPORT)
      hit_correct = target_valid && (target_box == cand);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      hit_valid  <= 1'b0;
      hit_box    <= '0;
      score      <= '0;
      miss_count <= '0;
    end else begin
      hit_valid <= 1'b0;

      // A clear in the REPORT cycle takes priority over counting that hit.
      if (score_clr) begin
        score      <= '0;
        miss_count <= '0;
      end else if (state == REPORT) begin
        if (hit_correct) begin
          if (score != '1) score <= score + SCORE_WIDTH'(1);
        end else begin
          if (miss_count != '1) miss_count <= miss_count + SCORE_WIDTH'(1);
        end
      end

      case (state)
        IDLE: begin
          if (sync_code != NO_HIT) begin
            cand  <= sync_code;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sync_code == NO_HIT) begin
            state <= IDLE;
          end else if (sync_code != cand) begin
            cand <= sync_code;
            cnt  <= '0;
          end else if (cnt == LAST) begin
            state     <= REPORT;
            hit_valid <= 1'b1;
            hit_box   <= cand;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          cnt   <= '0;
          state <= HOLD;
        end
        HOLD: begin
          if (sync_code != NO_HIT)
            cnt <= '0;
          else if (cnt == LAST)
            state <= IDLE;
          else
            cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector with DEBOUNCE_CYCLES=4, SCORE_WIDTH=4.
module tb_hit_detector;

  logic       clk;
  logic       reset;
  logic [2:0] box_address;
  logic [2:0] target_box;
  logic       target_valid;
  logic       score_clr;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic       hit_correct;
  logic [3:0] score;
  logic [3:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int dbl_cnt   = 0;
  logic prev_hv = 1'b0;
  int snap;

  hit_detector #(.DEBOUNCE_CYCLES(4), .SCORE_WIDTH(4)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .box_address  (box_address),
    .target_box   (target_box),
    .target_valid (target_valid),
    .score_clr    (score_clr),
    .hit_valid    (hit_valid),
    .hit_box      (hit_box),
    .hit_correct  (hit_correct),
    .score        (score),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter and back-to-back detector on hit_valid.
  always @(posedge clk) begin
    if (hit_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      if (prev_hv) dbl_cnt <= dbl_cnt + 1;
    end
    prev_hv <= hit_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full press: pulse 7 edges after driving, optional clear in REPORT,
  // then release long enough for HOLD to re-arm.
  task automatic press(input string tag, input logic [2:0] b, input logic exp_correct,
                       input logic clr_in_report);
    box_address = b;
    tick(6);
    check({tag, "_early"}, 16'(hit_valid), 16'd0);
    tick(1);
    check({tag, "_valid"}, 16'(hit_valid), 16'd1);
    check({tag, "_box"}, 16'(hit_box), 16'(b));
    check({tag, "_correct"}, 16'(hit_correct), 16'(exp_correct));
    score_clr = clr_in_report;
    tick(1);
    score_clr = 1'b0;
    box_address = 3'd0;
    tick(8);
  endtask

  initial begin
    reset = 1'b0; box_address = 3'd0; target_box = 3'd0;
    target_valid = 1'b0; score_clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_valid", 16'(hit_valid), 16'd0);
    check("rst_box", 16'(hit_box), 16'd0);
    check("rst_score", 16'(score), 16'd0);
    check("rst_miss", 16'(miss_count), 16'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Stable correct hit, then held with no second pulse
    target_box = 3'd3; target_valid = 1'b1;
    snap = pulse_cnt;
    box_address = 3'd3;
    tick(6);
    check("t1_early", 16'(hit_valid), 16'd0);
    tick(1);
    check("t1_valid", 16'(hit_valid), 16'd1);
    check("t1_box", 16'(hit_box), 16'd3);
    check("t1_correct", 16'(hit_correct), 16'd1);
    check("t1_score_pre", 16'(score), 16'd0);
    tick(1);
    check("t1_valid_low", 16'(hit_valid), 16'd0);
    check("t1_score", 16'(score), 16'd1);
    check("t1_miss", 16'(miss_count), 16'd0);
    tick(20);
    check("t1_pulses", 16'(pulse_cnt - snap), 16'd1);
    check("t1_box_hold", 16'(hit_box), 16'd3);
    box_address = 3'd0;
    tick(8);

    // Bounce 5/0 then hold 5, target invalid
    target_valid = 1'b0;
    snap = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      box_address = 3'd5; tick(2);
      box_address = 3'd0; tick(2);
    end
    check("t2_bounce_pulses", 16'(pulse_cnt - snap), 16'd0);
    press("t2", 3'd5, 1'b0, 1'b0);
    check("t2_miss", 16'(miss_count), 16'd1);
    check("t2_score", 16'(score), 16'd1);
    check("t2_pulses", 16'(pulse_cnt - snap), 16'd1);

    // Re-arm: short release does not re-arm, full release does
    target_box = 3'd2; target_valid = 1'b1;
    snap = pulse_cnt;
    box_address = 3'd2;
    tick(7);
    check("t3_valid", 16'(hit_valid), 16'd1);
    tick(4);
    box_address = 3'd0; tick(3);
    box_address = 3'd2; tick(12);
    check("t3_short_release", 16'(pulse_cnt - snap), 16'd1);
    box_address = 3'd0; tick(8);
    press("t3b", 3'd2, 1'b1, 1'b0);
    check("t3_pulses", 16'(pulse_cnt - snap), 16'd2);
    check("t3_score", 16'(score), 16'd3);

    // Saturation, then clear coinciding with REPORT
    score_clr = 1'b1; tick(1); score_clr = 1'b0;
    check("t4_clr_score", 16'(score), 16'd0);
    check("t4_clr_miss", 16'(miss_count), 16'd0);
    target_box = 3'd6;
    for (int i = 1; i <= 17; i++) begin
      press("t4_hit", 3'd6, 1'b1, 1'b0);
      check("t4_score", 16'(score), (i > 15) ? 16'd15 : 16'(i));
    end
    press("t4_clr_hit", 3'd6, 1'b1, 1'b1);
    check("t4_score_cleared", 16'(score), 16'd0);
    check("t4_miss_cleared", 16'(miss_count), 16'd0);

    // Wrong hit to leave nonzero state, then reset mid-DEBOUNCE
    target_box = 3'd3;
    press("t5_wrong", 3'd7, 1'b0, 1'b0);
    check("t5_miss", 16'(miss_count), 16'd1);
    check("t5_box", 16'(hit_box), 16'd7);
    box_address = 3'd4;
    tick(5);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_box", 16'(hit_box), 16'd0);
    check("t5_rst_miss", 16'(miss_count), 16'd0);
    check("t5_rst_valid", 16'(hit_valid), 16'd0);
    check("t5_rst_state", 16'(dut.state), 16'd0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("t5_early", 16'(hit_valid), 16'd0);
    tick(1);
    check("t5_valid", 16'(hit_valid), 16'd1);
    check("t5_box_after", 16'(hit_box), 16'd4);
    tick(1);
    box_address = 3'd0;
    tick(8);

    check("no_back_to_back", 16'(dbl_cnt), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_detector.md
HIT_DETECTOR -- requirements
Module: hit_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of stable clocks required to accept a code (10 ms at 50 MHz); legal minimum is 2.
REQ-002 Parameter SCORE_WIDTH, default 8, is the width of the score and miss counters.
REQ-003 CLOCK_50  input  1  is the single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-high reset.
REQ-005 box_address  input  3  is the raw sensor code from GPIO_1; 3'b000 means no hit, 1-7 is the struck box; it is asynchronous to CLOCK_50.
REQ-006 target_box  input  3  is the box currently lit by the game controller.
REQ-007 target_valid  input  1  means target_box is meaningful.
REQ-008 score_clr  input  1  is a synchronous single-cycle request to zero both counters.
REQ-009 hit_valid  output  1  is a one-cycle pulse per accepted hit.
REQ-010 hit_box  output  3  is the accepted box code; it holds its value until the next hit.
REQ-011 hit_correct  output  1  is valid with hit_valid and means the hit matched the target.
REQ-012 score  output  SCORE_WIDTH  is the count of correct hits.
REQ-013 miss_count  output  SCORE_WIDTH  is the count of wrong hits.

Function
REQ-014 box_address SHALL pass through a 2-flop synchronizer; all decisions below use the synchronized code (sync_code).
REQ-015 The FSM SHALL have four states: IDLE, DEBOUNCE, REPORT, HOLD.
REQ-016 IDLE: when sync_code != 0, the block captures cand = sync_code, sets cnt = 0 and goes to DEBOUNCE; otherwise it stays in IDLE.
REQ-017 DEBOUNCE, sync_code == 0: go to IDLE with no report.
REQ-018 DEBOUNCE, sync_code nonzero and != cand: set cand = sync_code, cnt = 0 and stay in DEBOUNCE.
REQ-019 DEBOUNCE, sync_code == cand: if cnt == DEBOUNCE_CYCLES-1, go to REPORT; otherwise increment cnt.
REQ-020 Latency with a stable input: if edge N is the first edge that samples a nonzero box_address, hit_valid is high in the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-021 REPORT lasts exactly one cycle:
- hit_valid = 1 and hit_box = cand.
- hit_correct = target_valid && (target_box == cand), sampled in this cycle only.
- The next state is HOLD.
REQ-022 On the edge leaving REPORT, score increments if hit_correct, otherwise miss_count increments; both counters saturate at all-ones.
REQ-023 HOLD re-arms the detector only after sync_code == 0 for DEBOUNCE_CYCLES consecutive clocks, then returns to IDLE.
- Any nonzero sync_code in HOLD, including a different box, restarts the count.
- A held sensor never produces a second hit.
REQ-024 score_clr zeroes both counters on the next edge; if it coincides with REPORT, the clear wins and that hit is not counted; hit_valid still pulses.
REQ-025 Changes to target_box or target_valid outside the REPORT cycle SHALL have no effect.
REQ-026 hit_valid SHALL never be high on two consecutive cycles.

Reset
REQ-027 Asserting reset SHALL immediately force all of the following, independent of the clock:
- state = IDLE;
- synchronizer flops, cand and cnt = 0;
- hit_valid, hit_box, hit_correct, score and miss_count = 0.
REQ-028 Reset during DEBOUNCE or HOLD SHALL discard the pending hit; after release, a still-pressed sensor is treated as a new press (full latency per REQ-020).

Structure
REQ-029 The shared package bytebasher_pkg SHALL hold the state encoding, NO_HIT = 3'b000, and DEFAULT_DEBOUNCE = 500000.
REQ-030 The synchronizer SHALL be a separate sub-module, sensor_sync (parameterized width, 2 stages); the FSM, counters and score logic stay in hit_detector.

Verification (DEBOUNCE_CYCLES=4, SCORE_WIDTH=4)
REQ-031 Stable correct hit: target_box=3, target_valid=1, box_address=3 held -> one hit_valid pulse 6 edges after first sample, with hit_box=3, hit_correct=1 and score=1; no further pulse while held.
REQ-032 Bounce: box_address toggles 5/0 every 2 cycles, then holds 5 -> no pulse during toggling; exactly one pulse with hit_box=5 after the hold; with target_valid=0, hit_correct=0 and miss_count=1.
REQ-033 Re-arm: hold 2, release for 3 cycles, press 2 again -> only one pulse total; after a 4-cycle release, a new press yields a second pulse.
REQ-034 Saturation and clear: 17 correct hits -> score stays at 15; a score_clr coinciding with the REPORT of the 18th hit -> score=0, with hit_valid still pulsing.
REQ-035 Reset mid-DEBOUNCE: assert reset at cnt=2 -> all outputs 0 immediately; after release with the input still held, the pulse arrives at the full latency.
